// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and default timing constants for the push-button front end.
//
// Contents:
//   btn_state_t              debounce / hold-timing FSM states (3-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES  stable synchronized cycles needed to accept an edge
//   DEFAULT_LONG_CYCLES      cycles held in PRESSED before a long press fires
//   level_of()               debounced button level implied by an FSM state
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_LONG_CYCLES     = 16;

    // The button counts as down in every state after a press has been
    // accepted, including while a release is still being debounced.
    function automatic logic level_of(input btn_state_t s);
        return (s == PRESSED) || (s == LONG_HELD) || (s == DEB_RELEASE);
    endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing the asynchronous button pin into the clk
// domain. Output is the input delayed by two rising edges.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset, clears both flops to 0
//   d      in   asynchronous input
//   q      out  synchronized output
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle
    // before anything downstream looks at the value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Turns a raw, bouncing push-button pin into a clean level plus one-cycle
// press / release / long-press pulses for a consumer FSM on the same clock.
// The pin is synchronized, then a debounce and hold-timing FSM accepts an edge
// only after DEBOUNCE_CYCLES consecutive agreeing samples, and flags a long
// press once the button has been held LONG_CYCLES cycles after acceptance.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept an edge (>=1, <=LONG_CYCLES)
//   LONG_CYCLES      cycles in PRESSED before long_press fires (>=2)
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   reset          in   asynchronous active-low reset (0 = reset)
//   btn_raw        in   raw button pin, asynchronous, active-high
//   B              out  debounced button level
//   press          out  one-cycle pulse on accepted press
//   release_pulse  out  one-cycle pulse on accepted release ("release" itself
//                       is a reserved word in SystemVerilog)
//   long_press     out  one-cycle pulse when a press has been held long enough
//   state_o        out  current FSM state encoding, for debug
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       B,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic [2:0] state_o
);

    // Both counters share one width sized for the longer of the two limits,
    // which is why DEBOUNCE_CYCLES must not exceed LONG_CYCLES.
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             btn_s;

    btn_state_t       state;
    btn_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_nx;
    logic             long_flag;
    logic             long_flag_nx;
    logic             press_nx;
    logic             release_nx;
    logic             long_nx;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // State and counter registers. Outputs are registered from the next-state
    // decode so they line up with the state they describe, and a reset simply
    // clears everything without producing any pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            long_flag     <= 1'b0;
            B             <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            hold          <= hold_nx;
            long_flag     <= long_flag_nx;
            B             <= level_of(state_nx);
            press         <= press_nx;
            release_pulse <= release_nx;
            long_press    <= long_nx;
        end
    end

    // Next-state logic. cnt times debounce windows in both directions; hold
    // times how long the button has been down and is deliberately left alone
    // while a release is being debounced, so a short release glitch neither
    // restarts nor advances the long-press timer.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        hold_nx      = hold;
        long_flag_nx = long_flag;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx = DEB_PRESS;
                    cnt_nx   = '0;
                end
            end

            DEB_PRESS: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nx     = PRESSED;
                    press_nx     = 1'b1;
                    hold_nx      = '0;
                    long_flag_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    state_nx = DEB_RELEASE;
                    cnt_nx   = '0;
                end else if (hold == LONG_LAST) begin
                    state_nx     = LONG_HELD;
                    long_nx      = 1'b1;
                    long_flag_nx = 1'b1;
                end else begin
                    hold_nx = hold + CNT_ONE;
                end
            end

            LONG_HELD: begin
                if (!btn_s) begin
                    state_nx = DEB_RELEASE;
                    cnt_nx   = '0;
                end
            end

            DEB_RELEASE: begin
                // A bounce back to pressed returns to whichever held state we
                // came from; long_flag remembers that without a sixth state.
                if (btn_s) begin
                    state_nx = long_flag ? LONG_HELD : PRESSED;
                end else if (cnt == DEB_LAST) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner. A run-length model of the
// debounce rules predicts every output each cycle; directed sequences pin the
// model with hand-computed latencies, and a randomized phase exercises bounce,
// glitches, long holds and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int LNG = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_raw = 1'b0;
    logic       B;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .B             (B),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural model: the pin is seen two edges late; an edge is accepted
    // once DEB+1 consecutive samples disagree with the current level (the first
    // one opens the window); a long press fires on the LNG-th steady pressed
    // sample after acceptance, not counting samples that end a glitch.
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_smp = 1'b0;
    logic m_level = 1'b0;
    int   m_run = 0;
    int   m_held = 0;
    logic m_long_done = 1'b0;
    logic e_press = 1'b0;
    logic e_rel = 1'b0;
    logic e_long = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
            m_held = 0; m_long_done = 1'b0;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        end else begin
            m_smp = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_raw;
            e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
            if (m_smp != m_level) begin
                m_run = m_run + 1;
                if (m_run == DEB + 1) begin
                    m_level = m_smp;
                    m_run = 0;
                    if (m_smp) begin
                        e_press = 1'b1;
                        m_held = 0;
                        m_long_done = 1'b0;
                    end else begin
                        e_rel = 1'b1;
                    end
                end
            end else if (m_run > 0) begin
                m_run = 0;
            end else if (m_level && !m_long_done) begin
                m_held = m_held + 1;
                if (m_held == LNG) begin
                    e_long = 1'b1;
                    m_long_done = 1'b1;
                end
            end
        end
    end

    function automatic int expected_state();
        if (!m_level) return (m_run > 0) ? 1 : 0;
        if (m_run > 0) return 4;
        return m_long_done ? 3 : 2;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_cnt);
        end
    endtask

    // Every-cycle comparison against the model, half a period after the edge.
    always @(negedge clk) begin
        check_output("B", int'(B), int'(m_level));
        check_output("press", int'(press), int'(e_press));
        check_output("release", int'(release_pulse), int'(e_rel));
        check_output("long_press", int'(long_press), int'(e_long));
        check_output("state_o", int'(state_o), expected_state());
    end

    function automatic logic pulse_of(input int which);
        case (which)
            0: return press;
            1: return release_pulse;
            default: return long_press;
        endcase
    endfunction

    // Waits at most max_cycles for the selected pulse; -1 if it never came.
    task automatic wait_pulse(input int which, input int max_cycles, output int edge_idx);
        edge_idx = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (pulse_of(which)) begin
                edge_idx = edge_cnt;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input logic level, input int cycles);
        btn_raw = level;
        repeat (cycles) @(negedge clk);
    endtask

    int edge0;
    int hit;
    int n_press;
    int n_rel;

    initial begin
        // Reset held with the button down: everything quiet.
        reset = 1'b0;
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        check_output("rst_B", int'(B), 0);
        check_output("rst_press", int'(press), 0);
        check_output("rst_release", int'(release_pulse), 0);
        check_output("rst_long", int'(long_press), 0);
        check_output("rst_state", int'(state_o), 0);

        // Release reset with the button still down: a normal debounced press.
        reset = 1'b1;
        edge0 = edge_cnt + 1;
        wait_pulse(0, 20, hit);
        check_output("rst_exit_press_edge", hit - edge0, 6);
        check_output("rst_exit_B", int'(B), 1);
        wait_pulse(2, 30, hit);
        check_output("long_edge", hit - edge0, 22);
        repeat (5) @(negedge clk);
        btn_raw = 1'b0;
        edge0 = edge_cnt + 1;
        wait_pulse(1, 20, hit);
        check_output("release_edge", hit - edge0, 6);
        check_output("release_B", int'(B), 0);
        apply_stimulus(1'b0, 6);

        // Clean press from idle.
        btn_raw = 1'b1;
        edge0 = edge_cnt + 1;
        wait_pulse(0, 20, hit);
        check_output("clean_press_edge", hit - edge0, 6);
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 1);
        wait_pulse(1, 20, hit);
        apply_stimulus(1'b0, 6);

        // Bounce rejected: three high cycles are not enough.
        n_press = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_raw = 1'b0;
            @(negedge clk);
            if (press) n_press++;
        end
        check_output("bounce_press_count", n_press, 0);
        check_output("bounce_state", int'(state_o), 0);
        check_output("bounce_B", int'(B), 0);

        // Release glitch while pressed: no pulses, level stays high.
        btn_raw = 1'b1;
        wait_pulse(0, 20, hit);
        apply_stimulus(1'b1, 3);
        n_press = 0;
        n_rel = 0;
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) btn_raw = 1'b1;
            @(negedge clk);
            if (press) n_press++;
            if (release_pulse) n_rel++;
        end
        check_output("glitch_release_count", n_rel, 0);
        check_output("glitch_press_count", n_press, 0);
        check_output("glitch_B", int'(B), 1);
        apply_stimulus(1'b0, 1);
        wait_pulse(1, 20, hit);
        apply_stimulus(1'b0, 6);

        // Async reset in LONG_HELD: outputs drop at once, no release pulse.
        btn_raw = 1'b1;
        wait_pulse(2, 40, hit);
        repeat (3) @(negedge clk);
        check_output("long_state", int'(state_o), 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("async_B", int'(B), 0);
        check_output("async_state", int'(state_o), 0);
        check_output("async_long", int'(long_press), 0);
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_rel = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (release_pulse) n_rel++;
        end
        check_output("async_release_count", n_rel, 0);

        // Randomized runs: short bursts mimic bounce, long ones real presses.
        for (int seg = 0; seg < 160; seg++) begin
            if ($urandom_range(0, 29) == 0) begin
                @(posedge clk);
                #3 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            if ($urandom_range(0, 2) == 0)
                apply_stimulus(~btn_raw, $urandom_range(1, 3));
            else
                apply_stimulus(~btn_raw, $urandom_range(4, 30));
        end
        apply_stimulus(1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
